uart_param: RTL and testbench

Parametrised successor UART with configurable data width, parity mode and stop-bit count. Uses valid/ready handshakes on both byte interfaces. The receiver uses a double-flop synchroniser, mid-bit sampling and false-start rejection, and flags parity, framing and overrun errors. It sits between board serial pins and the logger datapath, replacing the fixed 8N1 block.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/baud_timer.sv | 32 +++
 rtl/uart_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_param.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and the parity helper for the parametrised UART.
package uart_pkg;

  localparam int MAX_DATA = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA-1:0] data, input parity_t mode);
    logic x;
    x = ^data;
    case (mode)
      PAR_ODD:  return ~x;
      PAR_EVEN: return x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/baud_timer.sv
// Bit-period counter: half flags the mid-start sample point, tick ends a bit.
module baud_timer #(
  parameter int SYNC  = 16,
  parameter int ALIGN = SYNC / 2
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic half,
  output logic tick
);

  localparam int W = (SYNC > 1) ? $clog2(SYNC) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign half = (cnt_q == W'(ALIGN - 1));
  assign tick = (cnt_q == W'(SYNC - 1));

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_param.sv
// Parametrised UART with valid/ready byte interfaces, optional parity and
// a receiver that rejects false starts and reports parity/framing/overrun.
module uart_param
  import uart_pkg::*;
#(
  parameter int CLOCK  = 150000000,
  parameter int BAUD   = 9600,
  parameter int DATA   = 8,
  parameter int PARITY = 0,
  parameter int STOP   = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            rx,
  output logic            tx,
  input  logic [DATA-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [DATA-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun
);

  localparam int             SYNC     = CLOCK / BAUD;
  localparam int             ALIGN    = SYNC / 2;
  localparam int             BW       = $clog2(DATA + 1);
  localparam parity_t        PMODE    = parity_t'(PARITY);
  localparam logic [BW-1:0]  LAST_BIT = BW'(DATA - 1);

  // ---------------- transmitter ----------------
  tx_state_t       tx_state_q, tx_state_d;
  logic            tx_q, tx_d;
  logic [DATA-1:0] tx_shift_q, tx_shift_d;
  logic [BW-1:0]   tx_bit_q, tx_bit_d;
  logic            tx_par_q, tx_par_d;
  logic            tx_stop_q, tx_stop_d;
  logic            tx_tick, tx_half_unused;

  baud_timer #(.SYNC(SYNC), .ALIGN(ALIGN)) u_tx_timer (
    .clk  (clk),
    .clr  (clr || tx_state_q == TX_IDLE),
    .en   (1'b1),
    .half (tx_half_unused),
    .tick (tx_tick)
  );

  assign tx       = tx_q;
  assign tx_ready = (tx_state_q == TX_IDLE);

  // tx_d is the line level for the state being entered, so tx is registered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_d       = tx_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_d       = 1'b0;
          tx_shift_d = tx_data;
          tx_par_d   = calc_parity(MAX_DATA'(tx_data), PMODE);
          tx_bit_d   = '0;
          tx_stop_d  = 1'b0;
        end
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_d       = tx_shift_q[0];
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit_q == LAST_BIT) begin
          if (PMODE == PAR_NONE) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
          end
        end else begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_d       = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_tick) begin
        tx_state_d = TX_STOP;
        tx_d       = 1'b1;
      end
      TX_STOP: if (tx_tick) begin
        if (STOP == 2 && !tx_stop_q) tx_stop_d  = 1'b1;
        else                         tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_q       <= tx_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
    end
  end

  // NOTE: pure datapath registers are loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    tx_par_q   <= tx_par_d;
  end

  // ---------------- receiver ----------------
  logic            sync1_q, sync2_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [DATA-1:0] rx_shift_q, rx_shift_d;
  logic [BW-1:0]   rx_bit_q, rx_bit_d;
  logic            rx_par_q, rx_par_d;
  logic [DATA-1:0] rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_restart;
  logic            rx_half, rx_tick;

  baud_timer #(.SYNC(SYNC), .ALIGN(ALIGN)) u_rx_timer (
    .clk  (clk),
    .clr  (clr || rx_state_q == RX_IDLE || rx_restart),
    .en   (1'b1),
    .half (rx_half),
    .tick (rx_tick)
  );

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_shift_d   = rx_shift_q;
    rx_bit_d     = rx_bit_q;
    rx_par_d     = rx_par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    rx_restart   = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
    end
    unique case (rx_state_q)
      RX_IDLE: if (rx_prev_q && !sync2_q) begin
        rx_state_d = RX_START;
        rx_bit_d   = '0;
      end
      RX_START: if (rx_half) begin
        if (!sync2_q) begin
          rx_state_d = RX_DATA;
          rx_restart = 1'b1;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_d = {sync2_q, rx_shift_q[DATA-1:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == LAST_BIT) begin
          if (PMODE == PAR_NONE) rx_state_d = RX_STOP;
          else                   rx_state_d = RX_PARITY;
        end
      end
      RX_PARITY: if (rx_tick) begin
        rx_par_d   = sync2_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        // Only the first stop bit is checked; the line may start again right after.
        rx_state_d = RX_IDLE;
        if (!rx_valid_q || rx_ready) begin
          rx_data_d    = rx_shift_q;
          rx_valid_d   = 1'b1;
          frame_err_d  = !sync2_q;
          parity_err_d = (PMODE != PAR_NONE) &&
                         (rx_par_q != calc_parity(MAX_DATA'(rx_shift_q), PMODE));
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_bit_q     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      rx_prev_q    <= sync2_q;
      rx_state_q   <= rx_state_d;
      rx_bit_q     <= rx_bit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    rx_par_q   <= rx_par_d;
  end

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param at CLOCK=16, BAUD=1: tx waveform, loopback with even
// parity, driven rx frames from a vector table, glitch, overrun and mid-frame clear.
module tb_uart_param;

  localparam int SYNC = 16;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  // u_a: defaults 8N1
  logic       a_rx, a_tx, a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
  logic       a_perr, a_ferr, a_ovr;
  logic [7:0] a_tx_data, a_rx_data;
  // u_b: 7 data, even parity, 2 stop, looped back
  logic       b_line, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
  logic       b_perr, b_ferr, b_ovr;
  logic [6:0] b_tx_data, b_rx_data;
  // u_c: 8 data, odd parity, rx driven by the bench
  logic       c_rx, c_tx, c_tx_valid, c_tx_ready, c_rx_valid, c_rx_ready;
  logic       c_perr, c_ferr, c_ovr;
  logic [7:0] c_tx_data, c_rx_data;

  uart_param #(.CLOCK(16), .BAUD(1)) u_a (
    .clk(clk), .clr(clr), .rx(a_rx), .tx(a_tx),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr)
  );

  uart_param #(.CLOCK(16), .BAUD(1), .DATA(7), .PARITY(2), .STOP(2)) u_b (
    .clk(clk), .clr(clr), .rx(b_line), .tx(b_line),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .parity_err(b_perr), .frame_err(b_ferr), .overrun(b_ovr)
  );

  uart_param #(.CLOCK(16), .BAUD(1), .DATA(8), .PARITY(1), .STOP(1)) u_c (
    .clk(clk), .clr(clr), .rx(c_rx), .tx(c_tx),
    .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
    .parity_err(c_perr), .frame_err(c_ferr), .overrun(c_ovr)
  );

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  exp_t    sb_q[$];
  rx_vec_t vecs[4];
  int      n_checks = 0;
  int      n_pass   = 0;
  int      ovr_cnt  = 0;

  always @(posedge clk) if (c_ovr) ovr_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks so far %0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one byte into u_a and compare tx/tx_ready on every frame cycle.
  task automatic send_a_check(input logic [7:0] d, input string tag);
    logic [9:0] bits;
    bits       = {1'b1, d, 1'b0};
    a_tx_data  = d;
    a_tx_valid = 1'b1;
    tick();
    a_tx_valid = 1'b0;
    for (int k = 0; k < 10 * SYNC; k++) begin
      check({tag, "_tx"}, 32'(a_tx), 32'(bits[k / SYNC]));
      check({tag, "_rdy_busy"}, 32'(a_tx_ready), 32'd0);
      tick();
    end
    check({tag, "_rdy_done"}, 32'(a_tx_ready), 32'd1);
    check({tag, "_tx_idle"}, 32'(a_tx), 32'd1);
  endtask

  // Drive one odd-parity frame on c_rx, optionally corrupting parity or stop.
  task automatic send_c(input logic [7:0] d, input logic bad_par, input logic stop_bit);
    logic [10:0] bits;
    logic        p;
    p    = ~(^d) ^ bad_par;
    bits = {stop_bit, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      c_rx = bits[i];
      repeat (SYNC) tick();
    end
    c_rx = 1'b1;
  endtask

  task automatic wait_c_valid(input string tag);
    for (int i = 0; i < 64 && !c_rx_valid; i++) tick();
    check({tag, "_valid"}, 32'(c_rx_valid), 32'd1);
  endtask

  task automatic pop_compare_c(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_data"}, 32'(c_rx_data), 32'(e.data));
      check({tag, "_perr"}, 32'(c_perr), 32'(e.perr));
      check({tag, "_ferr"}, 32'(c_ferr), 32'(e.ferr));
    end
  endtask

  task automatic consume_c(input string tag);
    c_rx_ready = 1'b1;
    tick();
    c_rx_ready = 1'b0;
    check({tag, "_cleared_valid"}, 32'(c_rx_valid), 32'd0);
    check({tag, "_cleared_perr"}, 32'(c_perr), 32'd0);
    check({tag, "_cleared_ferr"}, 32'(c_ferr), 32'd0);
  endtask

  initial begin
    exp_t       e;
    logic [6:0] b_word;
    logic       seen;
    int         ovr_base;

    vecs[0] = '{8'h0F, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    clr = 1'b1;
    a_rx = 1'b1; a_tx_data = '0; a_tx_valid = 1'b0; a_rx_ready = 1'b0;
    b_tx_data = '0; b_tx_valid = 1'b0; b_rx_ready = 1'b0;
    c_rx = 1'b1; c_tx_data = '0; c_tx_valid = 1'b0; c_rx_ready = 1'b0;
    repeat (3) tick();
    clr = 1'b0;
    tick();

    // Reset state
    check("rst_tx", 32'(a_tx), 32'd1);
    check("rst_tx_ready", 32'(a_tx_ready), 32'd1);
    check("rst_rx_valid", 32'(a_rx_valid), 32'd0);
    check("rst_rx_data", 32'(a_rx_data), 32'd0);
    check("rst_perr", 32'(a_perr), 32'd0);
    check("rst_ferr", 32'(a_ferr), 32'd0);
    check("rst_ovr", 32'(a_ovr), 32'd0);
    check("rst_c_tx", 32'(c_tx), 32'd1);
    check("rst_c_rx_data", 32'(c_rx_data), 32'd0);

    // 8N1 waveform of 0x55
    send_a_check(8'h55, "a55");

    // Loopback 7E2 with 0x3A
    b_word     = 7'h3A;
    e.data     = 9'(b_word);
    e.perr     = 1'b0;
    e.ferr     = 1'b0;
    sb_q.push_back(e);
    b_tx_data  = b_word;
    b_tx_valid = 1'b1;
    tick();
    b_tx_valid = 1'b0;
    repeat (8 * SYNC + SYNC / 2) tick();
    check("b_parity_bit", 32'(b_line), 32'(^b_word));
    for (int i = 0; i < 200 && !b_rx_valid; i++) tick();
    check("b_valid", 32'(b_rx_valid), 32'd1);
    e = sb_q.pop_front();
    check("b_data", 32'(b_rx_data), 32'(e.data));
    check("b_perr", 32'(b_perr), 32'(e.perr));
    check("b_ferr", 32'(b_ferr), 32'(e.ferr));
    check("b_ovr", 32'(b_ovr), 32'd0);
    b_rx_ready = 1'b1;
    tick();
    b_rx_ready = 1'b0;
    check("b_consumed", 32'(b_rx_valid), 32'd0);
    repeat (3 * SYNC) tick();
    check("b_tx_ready_end", 32'(b_tx_ready), 32'd1);

    // Short low glitch must not start a frame
    c_rx = 1'b0;
    repeat (5) tick();
    c_rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (c_rx_valid) seen = 1'b1;
      tick();
    end
    check("glitch_no_valid", 32'(seen), 32'd0);

    // Table-driven rx frames
    for (int i = 0; i < 4; i++) begin
      e.data = 9'(vecs[i].exp_data);
      e.perr = vecs[i].exp_perr;
      e.ferr = vecs[i].exp_ferr;
      sb_q.push_back(e);
      send_c(vecs[i].data, vecs[i].bad_par, vecs[i].stop_bit);
      wait_c_valid($sformatf("vec%0d", i));
      pop_compare_c($sformatf("vec%0d", i));
      consume_c($sformatf("vec%0d", i));
      repeat (SYNC) tick();
    end

    // Overrun: second frame is dropped while the first is unconsumed
    ovr_base = ovr_cnt;
    e.data = 9'h011; e.perr = 1'b0; e.ferr = 1'b0;
    sb_q.push_back(e);
    send_c(8'h11, 1'b0, 1'b1);
    wait_c_valid("ovr_first");
    check("ovr_none_yet", 32'(ovr_cnt - ovr_base), 32'd0);
    repeat (SYNC) tick();
    send_c(8'h22, 1'b0, 1'b1);
    repeat (SYNC) tick();
    check("ovr_one_pulse", 32'(ovr_cnt - ovr_base), 32'd1);
    check("ovr_still_valid", 32'(c_rx_valid), 32'd1);
    pop_compare_c("ovr_kept");
    consume_c("ovr");
    check("c_tx_ready_end", 32'(c_tx_ready), 32'd1);

    // Clear during data bit 3 of 0x55, then a clean frame
    a_tx_data  = 8'h55;
    a_tx_valid = 1'b1;
    tick();
    a_tx_valid = 1'b0;
    repeat (4 * SYNC + 6) tick();
    check("clr_pre_tx_low", 32'(a_tx), 32'd0);
    check("clr_pre_busy", 32'(a_tx_ready), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_tx_high", 32'(a_tx), 32'd1);
    check("clr_tx_ready", 32'(a_tx_ready), 32'd1);
    send_a_check(8'hC3, "after_clr");
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
